// File: rtl/add_round_key_stage_if.sv
// Stream bus for the AddRoundKey stage: upstream state beat in, keyed result out.
// Signal names carry the stage's own direction suffixes (_i into the stage, _o out of it).
interface add_round_key_stage_if #(
  parameter int RW = 4
);
  logic          valid_i;
  logic          ready_o;
  logic [127:0]  state_i;
  logic          valid_o;
  logic          ready_i;
  logic [127:0]  state_o;
  logic [RW-1:0] round_o;
  logic          last_o;

  modport slave (
    input  valid_i, state_i, ready_i,
    output ready_o, valid_o, state_o, round_o, last_o
  );

  modport master (
    output valid_i, state_i, ready_i,
    input  ready_o, valid_o, state_o, round_o, last_o
  );
endinterface

// File: rtl/add_round_key_stage.sv
// Registered AES AddRoundKey stage with a local store of NR+1 round keys and a wrapping round counter.
// Optional macro ARK_KEY_CHECK_EN adds a sticky err_o for accepts that use a never-written key slot.
module add_round_key_stage #(
  parameter int NR = 10,
  parameter int RW = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          key_we_i,
  input  logic [RW-1:0] key_idx_i,
  input  logic [127:0]  key_i,
  input  logic          start_i,
`ifdef ARK_KEY_CHECK_EN
  output logic          err_o,
`endif
  add_round_key_stage_if.slave bus
);

  localparam logic [RW-1:0] LAST_RND = RW'(NR);

  logic [127:0]  r_key [0:NR];
  logic [NR:0]   w_slot_we;
  logic [RW-1:0] r_rnd;
  logic [RW-1:0] w_rnd_eff;
  logic [RW-1:0] r_round;
  logic [127:0]  r_state;
  logic [127:0]  w_key_sel;
  logic          r_valid;
  logic          r_last;
  logic          w_ready;
  logic          w_accept;

  // Decoding per slot means an out-of-range index simply matches no slot.
  genvar gi;
  generate
    for (gi = 0; gi <= NR; gi++) begin : g_slot_we
      assign w_slot_we[gi] = key_we_i && (key_idx_i == RW'(gi));
    end
  endgenerate

  assign w_ready   = !r_valid || bus.ready_i;
  assign w_accept  = bus.valid_i && w_ready;
  assign w_rnd_eff = start_i ? '0 : r_rnd;

  always_comb begin
    w_key_sel = '0;
    for (int i = 0; i <= NR; i++) begin
      if (w_rnd_eff == RW'(i)) w_key_sel = r_key[i];
    end
  end

  // Key read above uses the pre-edge contents, so a same-slot write lands after the accept.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i <= NR; i++) r_key[i] <= '0;
    end else begin
      for (int i = 0; i <= NR; i++) begin
        if (w_slot_we[i]) r_key[i] <= key_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rnd <= '0;
    end else if (w_accept) begin
      r_rnd <= (w_rnd_eff == LAST_RND) ? '0 : w_rnd_eff + RW'(1);
    end else if (start_i) begin
      r_rnd <= '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_state <= '0;
      r_round <= '0;
      r_last  <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_state <= bus.state_i ^ w_key_sel;
      r_round <= w_rnd_eff;
      r_last  <= (w_rnd_eff == LAST_RND);
    end else if (bus.ready_i) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.ready_o = w_ready;
  assign bus.valid_o = r_valid;
  assign bus.state_o = r_state;
  assign bus.round_o = r_round;
  assign bus.last_o  = r_last;

`ifdef ARK_KEY_CHECK_EN
  logic [NR:0] r_written;
  logic        w_sel_written;
  logic        r_err;

  always_comb begin
    w_sel_written = 1'b0;
    for (int i = 0; i <= NR; i++) begin
      if (w_rnd_eff == RW'(i)) w_sel_written = r_written[i];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_written <= '0;
      r_err     <= 1'b0;
    end else begin
      r_written <= r_written | w_slot_we;
      if (w_accept && !w_sel_written) r_err <= 1'b1;
    end
  end

  assign err_o = r_err;
`endif

endmodule

// File: tb/tb_add_round_key_stage.sv
// Randomized and directed bench for add_round_key_stage against a round-level reference model.
module tb_add_round_key_stage;
  localparam int NR = 10;
  localparam int RW = 4;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          key_we  = 1'b0;
  logic [RW-1:0] key_idx = '0;
  logic [127:0]  key     = '0;
  logic          start   = 1'b0;
`ifdef ARK_KEY_CHECK_EN
  logic          err;
`endif

  add_round_key_stage_if #(.RW(RW)) bus ();

  add_round_key_stage #(.NR(NR), .RW(RW)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .key_we_i  (key_we),
    .key_idx_i (key_idx),
    .key_i     (key),
    .start_i   (start),
`ifdef ARK_KEY_CHECK_EN
    .err_o     (err),
`endif
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: key table, current round number, and the single held result.
  logic [127:0] m_key [0:NR];
  logic [127:0] m_state;
  int           m_round;
  int           m_rnd;
  bit           m_valid;
  bit           m_last;
`ifdef ARK_KEY_CHECK_EN
  bit           m_written [0:NR];
  bit           m_err;
`endif

  task automatic check_val(string tag, logic [127:0] got, logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_reset();
    for (int i = 0; i <= NR; i++) begin
      m_key[i] = '0;
`ifdef ARK_KEY_CHECK_EN
      m_written[i] = 1'b0;
`endif
    end
`ifdef ARK_KEY_CHECK_EN
    m_err = 1'b0;
`endif
    m_state = '0;
    m_round = 0;
    m_rnd   = 0;
    m_valid = 1'b0;
    m_last  = 1'b0;
  endtask

  task automatic check_outputs();
    check_val("valid_o", 128'(bus.valid_o), 128'(m_valid));
    check_val("state_o", bus.state_o, m_state);
    check_val("round_o", 128'(bus.round_o), 128'(m_round));
    check_val("last_o", 128'(bus.last_o), 128'(m_last));
`ifdef ARK_KEY_CHECK_EN
    check_val("err_o", 128'(err), 128'(m_err));
`endif
  endtask

  // One clock: check ready_o, advance model over the edge, check outputs 1 time unit later.
  task automatic cycle();
    bit acc;
    int re;
    int ki;
    #1;
    check_val("ready_o", 128'(bus.ready_o), 128'(!m_valid || bus.ready_i));
    acc = bus.valid_i && (!m_valid || bus.ready_i);
    re  = start ? 0 : m_rnd;
    ki  = int'(key_idx);
    @(posedge clk);
    if (acc) begin
      m_state = bus.state_i ^ m_key[re];
      m_round = re;
      m_last  = (re == NR);
      m_valid = 1'b1;
      m_rnd   = (re + 1) % (NR + 1);
`ifdef ARK_KEY_CHECK_EN
      if (!m_written[re]) m_err = 1'b1;
`endif
      $display("beat round=%0d in=%h key=%h", re, bus.state_i, m_key[re]);
    end else begin
      if (start) m_rnd = 0;
      if (bus.ready_i) m_valid = 1'b0;
    end
    if (key_we && ki <= NR) begin
      m_key[ki] = key;
`ifdef ARK_KEY_CHECK_EN
      m_written[ki] = 1'b1;
`endif
    end
    #1;
    check_outputs();
  endtask

  task automatic write_key(int idx, logic [127:0] k);
    key_we      = 1'b1;
    key_idx     = RW'(idx);
    key         = k;
    bus.valid_i = 1'b0;
    cycle();
    key_we = 1'b0;
  endtask

  task automatic beat(logic [127:0] s, bit st);
    bus.valid_i = 1'b1;
    bus.state_i = s;
    start       = st;
    cycle();
    bus.valid_i = 1'b0;
    start       = 1'b0;
  endtask

  task automatic do_async_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] saved;
    logic [127:0] new_key;
    logic [3:0]   nib;
    int           exp_rnd;

    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    bus.state_i = '0;
    model_reset();
    #11;
    check_outputs();
    rst_n = 1'b1;
    #5;

    // FIPS-197 round 1
    write_key(1, 128'h2a6c7605_23a33939_88542cb1_a0fafe17);
    beat(rand128(), 1'b1);
    beat(128'h2806264c_48f8d37a_e0cb199a_046681e5, 1'b0);
    check_val("fips_state", bus.state_o, 128'h026a5049_6b5bea43_689f352b_a49c7ff2);
    check_val("fips_round", 128'(bus.round_o), 128'd1);
    check_val("fips_last", 128'(bus.last_o), 128'd0);

    // Wrap: 12 back-to-back beats over keys {32{i}}
    for (int i = 0; i <= NR; i++) begin
      nib = 4'(i);
      write_key(i, {32{nib}});
    end
    for (int j = 0; j < 12; j++) begin
      beat('0, j == 0);
      exp_rnd = (j <= NR) ? j : 0;
      nib     = 4'(exp_rnd);
      check_val("wrap_round", 128'(bus.round_o), 128'(exp_rnd));
      check_val("wrap_last", 128'(bus.last_o), 128'(j == NR));
      check_val("wrap_state", bus.state_o, {32{nib}});
    end

    // Backpressure with valid_i held
    bus.ready_i = 1'b0;
    bus.valid_i = 1'b1;
    bus.state_i = rand128();
    saved       = 128'(bus.round_o);
    exp_rnd     = m_rnd;
    repeat (3) begin
      cycle();
      check_val("bp_ready", 128'(bus.ready_o), 128'd0);
      check_val("bp_hold", 128'(bus.round_o), saved);
    end
    bus.ready_i = 1'b1;
    cycle();
    check_val("bp_accept", 128'(bus.round_o), 128'(exp_rnd));
    bus.valid_i = 1'b0;

    // Restart while the counter sits at 7
    for (int n = 0; n < NR + 1 && m_rnd != 7; n++) beat(rand128(), 1'b0);
    check_val("rnd_at_7", 128'(m_rnd), 128'd7);
    beat(rand128(), 1'b1);
    check_val("start_round0", 128'(bus.round_o), 128'd0);
    beat(rand128(), 1'b0);
    check_val("start_round1", 128'(bus.round_o), 128'd1);

    // Out-of-range key writes, then sweep every round
    write_key(11, rand128());
    write_key(15, rand128());
    for (int j = 0; j <= NR; j++) begin
      beat('0, j == 0);
      nib = 4'(j);
      check_val("oor_key", bus.state_o, {32{nib}});
    end

    // Same-slot write during accept reads the old key
    saved       = m_key[0];
    new_key     = rand128();
    key_we      = 1'b1;
    key_idx     = '0;
    key         = new_key;
    beat('0, 1'b1);
    key_we      = 1'b0;
    check_val("rbw_old", bus.state_o, saved);
    beat('0, 1'b1);
    check_val("rbw_new", bus.state_o, new_key);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      bus.valid_i = ($urandom_range(0, 3) != 0);
      bus.ready_i = ($urandom_range(0, 2) != 0);
      bus.state_i = rand128();
      start       = ($urandom_range(0, 7) == 0);
      key_we      = ($urandom_range(0, 3) == 0);
      key_idx     = RW'($urandom_range(0, 15));
      key         = rand128();
      cycle();
    end
    key_we      = 1'b0;
    start       = 1'b0;
    bus.valid_i = 1'b0;

    // Asynchronous reset while a result is held under backpressure
    bus.ready_i = 1'b0;
    beat(rand128(), 1'b0);
    check_val("pre_rst_valid", 128'(bus.valid_o), 128'd1);
    do_async_reset();
    bus.ready_i = 1'b1;
    beat(rand128(), 1'b0);
    check_val("post_rst_round", 128'(bus.round_o), 128'd0);

    // Unwritten slot 3 used at round 3
    do_async_reset();
    for (int i = 0; i < 3; i++) write_key(i, rand128());
    for (int j = 0; j < 3; j++) beat(rand128(), j == 0);
    beat(rand128(), 1'b0);
    check_val("unwritten_round", 128'(bus.round_o), 128'd3);
    write_key(3, rand128());
    beat(rand128(), 1'b1);
    beat(rand128(), 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
